// File: rtl/result_buffer.sv
// Result FIFO that stores ALU results and their sign flags.
// Reads have one cycle of latency, and overflow/underflow flags stay set once raised.
module result_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         Result,
  input  logic                     sign,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_sign,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic             sign;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          rd_acc, wr_acc;

  // The flags decode the registered count, so they update in the same cycle as count.
  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));

  // When the buffer is full, a read in the same cycle frees a slot, so the write is still accepted.
  assign rd_acc = rd_en & ~empty & ~reset;
  assign wr_acc = wr_en & (~full | rd_acc) & ~reset;

  // The storage array has no reset.
  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr] <= entry_t'{sign: sign, data: Result};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_sign   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr].data;
        rd_sign <= mem[rd_ptr].sign;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_en && !wr_acc) overflow  <= 1'b1;
      if (rd_en && !rd_acc) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_result_buffer.sv
// Bench for result_buffer. It runs directed table vectors and hand-written corner sequences,
// then checks randomized traffic against a queue-based reference model.
module tb_result_buffer;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] Result = '0;
  logic             sign = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic             rd_sign, rd_valid, full, empty, overflow, underflow;
  logic [3:0]       count;

  result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .Result(Result), .sign(sign),
    .wr_en(wr_en), .rd_en(rd_en), .rd_data(rd_data), .rd_sign(rd_sign),
    .rd_valid(rd_valid), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int vcnt   = 0;

  typedef struct packed { logic s; logic [7:0] d; } ent_t;
  ent_t q[$];
  logic m_valid, m_ovf, m_unf;
  ent_t m_last;

  typedef struct {
    logic       w, r;
    logic [7:0] d;
    logic       s;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_sign;
    int         e_count;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_last = '0;
  endtask

  task automatic model_step(input logic w, input logic r, input logic [7:0] d, input logic s);
    bit rok, wok;
    rok = r && (q.size() > 0);
    wok = w && ((q.size() < DEPTH) || rok);
    m_valid = rok;
    if (rok) m_last = q.pop_front();
    if (wok) q.push_back(ent_t'{s: s, d: d});
    if (w && !wok) m_ovf = 1'b1;
    if (r && !rok) m_unf = 1'b1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " rd_valid"},  32'(rd_valid),  32'(m_valid));
    chk({tag, " rd_data"},   32'(rd_data),   32'(m_last.d));
    chk({tag, " rd_sign"},   32'(rd_sign),   32'(m_last.s));
    chk({tag, " count"},     32'(count),     32'(q.size()));
    chk({tag, " full"},      32'(full),      32'(q.size() == DEPTH));
    chk({tag, " empty"},     32'(empty),     32'(q.size() == 0));
    chk({tag, " overflow"},  32'(overflow),  32'(m_ovf));
    chk({tag, " underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  // Drive one cycle of requests, then sample just after the edge.
  task automatic drive(input logic w, input logic r, input logic [7:0] d, input logic s);
    wr_en = w; rd_en = r; Result = d; sign = s;
    @(posedge clock);
    #1;
    model_step(w, r, d, s);
    if (rd_valid) vcnt++;
  endtask

  task automatic cyc(input string tag, input logic w, input logic r, input logic [7:0] d, input logic s);
    drive(w, r, d, s);
    check_model(tag);
  endtask

  task automatic do_reset();
    wr_en = 0; rd_en = 0;
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    // Vectors for two write/read pairs, a rejected read, and a write plus read while empty.
    tbl[0] = '{1, 0, 8'h05, 1, 0, 8'h00, 0, 1};
    tbl[1] = '{1, 0, 8'hFB, 0, 0, 8'h00, 0, 2};
    tbl[2] = '{0, 1, 8'h00, 0, 1, 8'h05, 1, 1};
    tbl[3] = '{0, 1, 8'h00, 0, 1, 8'hFB, 0, 0};
    tbl[4] = '{0, 1, 8'h00, 0, 0, 8'hFB, 0, 0};
    tbl[5] = '{1, 1, 8'h77, 0, 0, 8'hFB, 0, 1};
    tbl[6] = '{0, 1, 8'h00, 0, 1, 8'h77, 0, 0};

    #3;
    chk("reset count",    32'(count),    0);
    chk("reset empty",    32'(empty),    1);
    chk("reset full",     32'(full),     0);
    chk("reset rd_valid", 32'(rd_valid), 0);
    chk("reset rd_data",  32'(rd_data),  0);
    chk("reset flags",    32'({overflow, underflow}), 0);
    do_reset();

    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].w, tbl[i].r, tbl[i].d, tbl[i].s);
      chk($sformatf("tbl%0d rd_valid", i), 32'(rd_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d rd_data", i),  32'(rd_data),  32'(tbl[i].e_data));
      chk($sformatf("tbl%0d rd_sign", i),  32'(rd_sign),  32'(tbl[i].e_sign));
      chk($sformatf("tbl%0d count", i),    32'(count),    32'(tbl[i].e_count));
    end
    chk("tbl underflow", 32'(underflow), 1);
    chk("tbl overflow",  32'(overflow),  0);
    chk("tbl empty",     32'(empty),     1);

    // Fill the buffer, drop a write while full, then drain it.
    do_reset();
    for (int i = 0; i < 8; i++) cyc("fill", 1, 0, 8'h10 + 8'(i), 0);
    chk("fill full", 32'(full), 1);
    chk("fill count", 32'(count), 8);
    cyc("drop", 1, 0, 8'hAA, 1);
    chk("drop overflow", 32'(overflow), 1);
    for (int i = 0; i < 8; i++) cyc("drain", 0, 1, 8'h00, 0);
    cyc("drain idle", 0, 0, 8'h00, 0);

    // Write and read in the same cycle while full.
    do_reset();
    for (int i = 0; i < 8; i++) cyc("fill2", 1, 0, 8'h10 + 8'(i), 0);
    cyc("full rw", 1, 1, 8'h3C, 1);
    chk("full rw data", 32'(rd_data), 32'h10);
    chk("full rw count", 32'(count), 8);
    chk("full rw ovf", 32'(overflow), 0);
    for (int i = 0; i < 8; i++) cyc("drain2", 0, 1, 8'h00, 0);
    chk("drain2 last", 32'({rd_sign, rd_data}), 32'h13C);

    // Twenty write/read pairs, so the pointers wrap.
    do_reset();
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc("pair w", 1, 0, 8'h40 + 8'(i), i[0]);
      cyc("pair r", 0, 1, 8'h00, 0);
    end
    cyc("pair idle", 0, 0, 8'h00, 0);
    chk("pair valid cycles", 32'(vcnt), 20);

    // Assert reset between clock edges.
    do_reset();
    for (int i = 0; i < 3; i++) cyc("pre-rst", 1, 0, 8'h60 + 8'(i), 1);
    cyc("pre-rst rd", 0, 1, 8'h00, 0);
    chk("pre-rst valid", 32'(rd_valid), 1);
    rd_en = 0;
    #3 reset = 1'b1;
    #1;
    model_reset();
    chk("async count",    32'(count),    0);
    chk("async empty",    32'(empty),    1);
    chk("async overflow", 32'(overflow), 0);
    chk("async rd_valid", 32'(rd_valid), 0);
    chk("async rd_data",  32'(rd_data),  0);
    wr_en = 1; Result = 8'h99;
    @(posedge clock); #1;
    chk("held in reset count", 32'(count), 0);
    @(negedge clock);
    reset = 1'b0;
    cyc("post-rst rd", 0, 1, 8'h00, 0);
    chk("post-rst underflow", 32'(underflow), 1);

    // Randomized traffic with a bias that changes every 50 cycles.
    do_reset();
    for (int ph = 0; ph < 8; ph++) begin
      int wb;
      wb = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 50 : 20;
      for (int i = 0; i < 50; i++) begin
        logic w, r;
        w = ($urandom_range(0, 99) < wb);
        r = ($urandom_range(0, 99) < (100 - wb));
        cyc("rand", w, r, 8'($urandom), 1'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/result_buffer.md
RESULT_BUFFER -- requirements
Module: result_buffer

Interface
REQ-001 Parameter WIDTH, default 8, data width of the stored ALU result.
REQ-002 Parameter DEPTH, default 8, number of entries; SHALL be a power of two, minimum 2.
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 reset  input  1  reset, asynchronous and active-high.
REQ-005 Result  input  WIDTH  ALU result to be stored.
REQ-006 sign  input  1  ALU sign flag stored alongside Result.
REQ-007 wr_en  input  1  write request, sampled on posedge clock.
REQ-008 rd_en  input  1  read request, sampled on posedge clock.
REQ-009 rd_data  output  WIDTH  registered read result.
REQ-010 rd_sign  output  1  registered sign paired with rd_data.
REQ-011 rd_valid  output  1  rd_data/rd_sign valid this cycle.
REQ-012 full  output  1  count == DEPTH.
REQ-013 empty  output  1  count == 0.
REQ-014 count  output  log2(DEPTH)+1  number of stored entries.
REQ-015 overflow  output  1  sticky: a write was dropped.
REQ-016 underflow  output  1  sticky: a read was rejected.

Function
REQ-017 Storage SHALL be DEPTH entries of WIDTH+1 bits holding {sign, Result}; storage contents SHALL NOT be reset.
REQ-018 Accepted write: wr_en=1 and (full=0 or an accepted read occurs in the same cycle); {sign, Result} written at wr_ptr, wr_ptr increments.
REQ-019 Accepted read: rd_en=1 and empty=0; entry at rd_ptr loaded into rd_data/rd_sign, rd_ptr increments, rd_valid=1 on the following cycle.
REQ-020 Read latency SHALL be exactly 1 cycle: rd_en accepted at edge N gives rd_valid=1 and the data during cycle N+1 through edge N+1.
REQ-021 rd_valid SHALL be 0 in any cycle not following an accepted read; rd_data/rd_sign SHALL hold their last value when rd_valid=0.
REQ-022 wr_ptr and rd_ptr SHALL wrap modulo DEPTH (DEPTH-1 -> 0).
REQ-023 count: +1 on write only, -1 on read only, unchanged on simultaneous accepted read and write.
REQ-024 full and empty SHALL be derived from the registered count, not from the pointers, with no added cycle of lag.
REQ-025 Write while full with no accepted read: write dropped, storage unchanged, overflow set to 1.
REQ-026 Read while empty: rejected, rd_valid=0 next cycle, underflow set to 1; no bypass of a simultaneous write.
REQ-027 Simultaneous wr_en and rd_en when full: both accepted, oldest entry read, new entry written to the freed slot, overflow not set.
REQ-028 Simultaneous wr_en and rd_en when empty: write accepted, read rejected, count becomes 1, underflow set.
REQ-029 overflow and underflow SHALL remain 1 until reset.
REQ-030 Arithmetic on pointers and count SHALL be unsigned; count SHALL never exceed DEPTH or go below 0.

Reset
REQ-031 reset=1 SHALL immediately, without waiting for a clock edge, force wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_valid=0, rd_data=0, rd_sign=0, overflow=0, underflow=0.
REQ-032 reset asserted mid-operation SHALL discard all stored entries logically (empty=1); a rd_en in the first edge after reset release is rejected.
REQ-033 Deassertion of reset SHALL take effect at the next posedge clock; no request is accepted while reset=1.

Verification
REQ-034 Reset, then write Result=8'h05 sign=1, Result=8'hFB sign=0, then read twice -> rd_valid pulses with {1,05} then {0,FB}, empty=1, count=0.
REQ-035 Write 8 entries 8'h10..8'h17 -> full=1, count=8; 9th write 8'hAA -> dropped, overflow=1; drain 8 -> 8'h10..8'h17 in order, 8'hAA never appears.
REQ-036 Fill to full, then assert wr_en (8'h3C) and rd_en in one cycle -> rd_data=8'h10, count stays 8, overflow=0; later drain ends with 8'h3C.
REQ-037 From empty, assert rd_en alone -> rd_valid=0 next cycle, underflow=1, count=0; simultaneous wr_en 8'h77 + rd_en on empty -> count=1, then a read returns 8'h77.
REQ-038 Perform 20 write/read pairs with distinct values -> pointers wrap twice, every value is returned in order, rd_valid high exactly 20 cycles.
REQ-039 Write 3 entries, assert reset between clock edges -> count=0, empty=1, overflow=0, rd_valid=0 immediately; a post-reset read is rejected.
